// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - uart_state_e : transmitter FSM state encoding
//   - REG_*        : register offsets (i_addr[3:2])
//   - ST_*         : STATUS register bit positions
//   - reset_div()  : divisor that produces BAUD from CLK_HZ
//   - even_parity(): parity bit that makes the frame's count of ones even
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_PARITY = 3'd3,
      UART_STOP   = 3'd4
   } uart_state_e;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int unsigned ST_FULL   = 32'd0;
   localparam int unsigned ST_EMPTY  = 32'd1;
   localparam int unsigned ST_ACTIVE = 32'd2;
   localparam int unsigned ST_OVF    = 32'd3;
   localparam int unsigned ST_PARITY = 32'd4;
   localparam int unsigned ST_LVL_LO = 32'd8;

   // Bit period is DIV+1 cycles, so the divisor is one less than the ratio.
   function automatic logic [15:0] reset_div(input int unsigned clk_hz,
                                             input int unsigned baud);
      int unsigned ratio;
      ratio = (clk_hz / baud) - 32'd1;
      return ratio[15:0];
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// LSU data-memory bus as seen by an IO responder.
//   i_we / i_re   : store / load strobes from the LSU
//   i_addr        : byte address
//   i_wdata       : store data
//   o_rdata       : load data returned into the LSU read-data OR-tree
// master = LSU side, slave = peripheral side.
interface mmio_uart_tx_if;
   import uart_pkg::*;

   logic        i_we;
   logic        i_re;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;

   modport master (output i_we, output i_re, output i_addr, output i_wdata,
                   input  o_rdata);
   modport slave  (input  i_we, input  i_re, input  i_addr, input  i_wdata,
                   output o_rdata);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
//   i_clk, rst   : clock, synchronous active-low reset (clears pointers only)
//   push, wdata  : write request; ignored while full
//   pop, rdata   : read request; rdata shows the head entry combinationally
//   full, empty  : occupancy flags
//   level        : number of stored entries (0..DEPTH)
// Fullness is judged on the state before the edge, so a push that meets a
// pop on a full FIFO is still dropped.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign level     = wr_ptr_r - rd_ptr_r;
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge i_clk) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Storage array write.
   always_ff @(posedge i_clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8 data bits, 1 stop bit, LSB first).
//   i_clk, rst : clock, synchronous active-low reset
//   bus        : LSU data-memory bus (slave modport), 16-byte window at BASE_ADDR
//                +0x0 TXDATA (W push byte, R 0)
//                +0x4 STATUS (R flags/level, W bit3=1 clears overflow)
//                +0x8 DIV    (R/W 16-bit divisor, bit period DIV+1 cycles)
//                +0xC reserved
//   o_txd      : registered serial output, idle high
//   o_busy     : registered, high while bytes are queued or a frame is in flight
// Build option: define MMIO_UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (STATUS bit4 then reads 1).
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_4000,
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic           i_clk,
   input  logic           rst,
   mmio_uart_tx_if.slave  bus,
   output logic           o_txd,
   output logic           o_busy
);
   localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_RST = reset_div(CLK_HZ, BAUD);

   localparam logic [2:0] S_IDLE  = UART_IDLE;
   localparam logic [2:0] S_START = UART_START;
   localparam logic [2:0] S_DATA  = UART_DATA;
   localparam logic [2:0] S_STOP  = UART_STOP;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY   = UART_PARITY;
   localparam logic [2:0] S_POSTDATA = S_PARITY;
   localparam logic       PARITY_ON  = 1'b1;
`else
   localparam logic [2:0] S_POSTDATA = S_STOP;
   localparam logic       PARITY_ON  = 1'b0;
`endif

   logic          sel_s;
   logic [1:0]    off_s;
   logic          wr_tx_s;
   logic          wr_st_s;
   logic          wr_div_s;
   logic [7:0]    fifo_dout_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [LW-1:0] fifo_level_s;
   logic [3:0]    lvl4_s;
   logic          pop_s;
   logic          bit_end_s;
   logic          txd_s;
   logic [2:0]    state_nx_s;
   logic [31:0]   status_s;
   logic [31:0]   rdata_s;
   logic          unused_s;

   logic [2:0]    state_r;
   logic [15:0]   div_r;
   logic [15:0]   div_sh_r;
   logic [15:0]   timer_r;
   logic [2:0]    bit_idx_r;
   logic [7:0]    shift_r;
   logic          ovf_r;
   logic          txd_r;
   logic          busy_r;

   assign sel_s     = (bus.i_addr[31:4] == BASE_ADDR[31:4]);
   assign off_s     = bus.i_addr[3:2];
   assign wr_tx_s   = sel_s && bus.i_we && (off_s == REG_TXDATA);
   assign wr_st_s   = sel_s && bus.i_we && (off_s == REG_STATUS);
   assign wr_div_s  = sel_s && bus.i_we && (off_s == REG_DIV);
   assign bit_end_s = (timer_r == div_sh_r);
   assign lvl4_s    = 4'(fifo_level_s);
   assign unused_s  = ^{bus.i_addr[1:0], bus.i_wdata[31:16]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .rst   (rst),
      .push  (wr_tx_s),
      .pop   (pop_s),
      .wdata (bus.i_wdata[7:0]),
      .rdata (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level_s)
   );

   // Next-state logic; IDLE pops the head byte as soon as one is queued.
   always_comb begin
      state_nx_s = state_r;
      pop_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s      = 1'b1;
               state_nx_s = S_START;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) state_nx_s = S_DATA;
            else           state_nx_s = S_START;
         end
         S_DATA: begin
            if (bit_end_s && (bit_idx_r == 3'd7)) state_nx_s = S_POSTDATA;
            else                                  state_nx_s = S_DATA;
         end
`ifdef MMIO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end_s) state_nx_s = S_STOP;
            else           state_nx_s = S_PARITY;
         end
`endif
         S_STOP: begin
            if (bit_end_s) state_nx_s = S_IDLE;
            else           state_nx_s = S_STOP;
         end
         default: state_nx_s = S_IDLE;
      endcase
   end

   // Line level for the current state; registered one cycle later into o_txd.
   always_comb begin
      txd_s = 1'b1;
      case (state_r)
         S_IDLE:   txd_s = 1'b1;
         S_START:  txd_s = 1'b0;
         S_DATA:   txd_s = shift_r[bit_idx_r];
`ifdef MMIO_UART_TX_PARITY_EN
         S_PARITY: txd_s = even_parity(shift_r);
`endif
         S_STOP:   txd_s = 1'b1;
         default:  txd_s = 1'b1;
      endcase
   end

   // FSM, bit timer and frame shadow registers; DIV is sampled only at pop.
   always_ff @(posedge i_clk) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         timer_r   <= 16'd0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         div_sh_r  <= DIV_RST;
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         txd_r   <= txd_s;
         busy_r  <= !fifo_empty_s || (state_r != S_IDLE);
         if (state_r == S_IDLE) begin
            timer_r   <= 16'd0;
            bit_idx_r <= 3'd0;
            if (pop_s) begin
               shift_r  <= fifo_dout_s;
               div_sh_r <= div_r;
            end
         end else if (bit_end_s) begin
            timer_r <= 16'd0;
            if (state_r == S_DATA) begin
               bit_idx_r <= bit_idx_r + 3'd1;
            end
         end else begin
            timer_r <= timer_r + 16'd1;
         end
      end
   end

   // Programmable divisor and sticky overflow flag.
   always_ff @(posedge i_clk) begin
      if (!rst) begin
         div_r <= DIV_RST;
         ovf_r <= 1'b0;
      end else begin
         if (wr_div_s) begin
            div_r <= bus.i_wdata[15:0];
         end
         if (wr_tx_s && fifo_full_s) begin
            ovf_r <= 1'b1;
         end else if (wr_st_s && bus.i_wdata[ST_OVF]) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Side-effect-free read mux; zero unless selected and loading.
   always_comb begin
      status_s                   = 32'd0;
      status_s[ST_FULL]          = fifo_full_s;
      status_s[ST_EMPTY]         = fifo_empty_s;
      status_s[ST_ACTIVE]        = (state_r != S_IDLE);
      status_s[ST_OVF]           = ovf_r;
      status_s[ST_PARITY]        = PARITY_ON;
      status_s[ST_LVL_LO +: 4]   = lvl4_s;
      rdata_s                    = 32'd0;
      if (sel_s && bus.i_re) begin
         case (off_s)
            REG_STATUS: rdata_s = status_s;
            REG_DIV:    rdata_s = {16'd0, div_r};
            REG_TXDATA: rdata_s = 32'd0;
            REG_RSVD:   rdata_s = 32'd0;
            default:    rdata_s = 32'd0;
         endcase
      end else begin
         rdata_s = 32'd0;
      end
   end

   assign bus.o_rdata = rdata_s;
   assign o_txd       = txd_r;
   assign o_busy      = busy_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with default parameters
// (reset divisor 50_000_000/115_200 - 1 = 433).
module tb_mmio_uart_tx;
   import uart_pkg::*;

   localparam logic [31:0] BASE    = 32'h1000_4000;
   localparam logic [31:0] A_TX    = BASE + 32'h0;
   localparam logic [31:0] A_ST    = BASE + 32'h4;
   localparam logic [31:0] A_DIV   = BASE + 32'h8;
   localparam logic [31:0] A_RSVD  = BASE + 32'hC;
   localparam logic [31:0] DIV_RST = 32'd433;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int          NB      = 11;
   localparam logic [31:0] PB      = 32'h10;
`else
   localparam int          NB      = 10;
   localparam logic [31:0] PB      = 32'h0;
`endif

   logic i_clk;
   logic rst;
   logic txd;
   logic busy;
   int   checks_cnt;
   int   fail_cnt;

   mmio_uart_tx_if bus_if ();

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .CLK_HZ     (50_000_000),
      .BAUD       (115_200),
      .FIFO_DEPTH (8)
   ) dut (
      .i_clk  (i_clk),
      .rst    (rst),
      .bus    (bus_if.slave),
      .o_txd  (txd),
      .o_busy (busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Store lands on the posedge between the two negedges.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge i_clk);
      bus_if.i_we    = 1'b1;
      bus_if.i_addr  = a;
      bus_if.i_wdata = d;
      @(negedge i_clk);
      bus_if.i_we    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus_if.i_re   = 1'b1;
      bus_if.i_addr = a;
      #1;
      d = bus_if.o_rdata;
      bus_if.i_re   = 1'b0;
   endtask

   // Waits for a start bit, then samples the first cycle of every later bit.
   task automatic rx_byte(input int div, output logic [7:0] b, output logic ok);
      int n;
      logic stop_b;
      logic par_ok;
      b      = 8'h00;
      ok     = 1'b0;
      par_ok = 1'b1;
      n      = 0;
      while (txd !== 1'b0 && n < 600) begin
         @(negedge i_clk);
         n++;
      end
      if (txd === 1'b0) begin
         for (int k = 0; k < 8; k++) begin
            repeat (div + 1) @(negedge i_clk);
            b[k] = txd;
         end
`ifdef MMIO_UART_TX_PARITY_EN
         repeat (div + 1) @(negedge i_clk);
         par_ok = (txd === ^b);
`endif
         repeat (div + 1) @(negedge i_clk);
         stop_b = txd;
         ok     = (stop_b === 1'b1) && par_ok;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [10:0] pat;
      logic [7:0]  b_a;
      logic        ok_a;
      logic [7:0]  b_b;
      logic        ok_b;
      checks_cnt     = 0;
      fail_cnt       = 0;
      rst            = 1'b0;
      bus_if.i_we    = 1'b0;
      bus_if.i_re    = 1'b0;
      bus_if.i_addr  = 32'd0;
      bus_if.i_wdata = 32'd0;

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      @(negedge i_clk);
      bus_if.i_addr = A_ST;
      #1;
      chk("rst_rdata_no_re", bus_if.o_rdata, 32'd0);
      bus_read(A_ST, rd);   chk("rst_status", rd, 32'h2 | PB);
      bus_read(A_DIV, rd);  chk("rst_div", rd, DIV_RST);

      // Single frame 0x55 at DIV=3
      bus_write(A_DIV, 32'd3);
      bus_read(A_DIV, rd);  chk("div_rb", rd, 32'd3);
      bus_write(A_TX, 32'h55);
      bus_read(A_ST, rd);   chk("t1_level1", rd, 32'h100 | PB);
      chk("t1_txd_n", {31'd0, txd}, 32'd1);
      @(negedge i_clk);
      chk("t1_txd_n1", {31'd0, txd}, 32'd1);
      chk("t1_busy_n1", {31'd0, busy}, 32'd1);
`ifdef MMIO_UART_TX_PARITY_EN
      pat = {1'b1, 1'b0, 8'h55, 1'b0};
`else
      pat = {1'b0, 1'b1, 8'h55, 1'b0};
`endif
      for (int i = 0; i < NB * 4; i++) begin
         @(negedge i_clk);
         chk("t1_bit", {31'd0, txd}, {31'd0, pat[i / 4]});
      end
      chk("t1_busy_last", {31'd0, busy}, 32'd1);
      @(negedge i_clk);
      chk("t1_busy_end", {31'd0, busy}, 32'd0);
      chk("t1_txd_end", {31'd0, txd}, 32'd1);

      // Overflow: one frame in flight, then 9 pushes back to back at DIV=0
      bus_write(A_TX, 32'hAA);
      fork
         begin
            rx_byte(3, b_a, ok_a);
            chk("t2_first_byte", {24'd0, b_a}, 32'hAA);
            chk("t2_first_ok", {31'd0, ok_a}, 32'd1);
         end
         begin
            @(negedge i_clk);
            bus_if.i_we    = 1'b1;
            bus_if.i_addr  = A_DIV;
            bus_if.i_wdata = 32'd0;
            for (int i = 0; i < 9; i++) begin
               @(negedge i_clk);
               bus_if.i_addr  = A_TX;
               bus_if.i_wdata = i;
            end
            @(negedge i_clk);
            bus_if.i_we = 1'b0;
            bus_read(A_ST, rd);
            chk("t2_full_status", rd, 32'h80D | PB);
         end
      join
      for (int i = 0; i < 8; i++) begin
         rx_byte(0, b_b, ok_b);
         chk("t2_byte", {24'd0, b_b}, i);
         chk("t2_byte_ok", {31'd0, ok_b}, 32'd1);
      end
      wait_idle("t2_idle");
      bus_read(A_ST, rd);   chk("t2_empty_ovf", rd, 32'hA | PB);

      // Overflow clear
      bus_write(A_ST, 32'h0000_0007);
      bus_read(A_ST, rd);   chk("t3_ovf_kept", rd, 32'hA | PB);
      bus_write(A_ST, 32'h0000_0008);
      bus_read(A_ST, rd);   chk("t3_ovf_clr", rd, 32'h2 | PB);

      // DIV shadowing
      bus_write(A_DIV, 32'd3);
      bus_write(A_TX, 32'h35);
      fork
         begin
            rx_byte(3, b_a, ok_a);
            chk("t4_frame1", {24'd0, b_a}, 32'h35);
            chk("t4_frame1_ok", {31'd0, ok_a}, 32'd1);
            rx_byte(7, b_b, ok_b);
            chk("t4_frame2", {24'd0, b_b}, 32'hA3);
            chk("t4_frame2_ok", {31'd0, ok_b}, 32'd1);
         end
         begin
            bus_write(A_TX, 32'hA3);
            bus_write(A_DIV, 32'd7);
         end
      join
      wait_idle("t4_idle");

      // Reset during DATA bit 4
      bus_write(A_DIV, 32'd3);
      bus_write(A_TX, 32'h5A);
      bus_write(A_TX, 32'h33);
      bus_read(A_ST, rd);   chk("t5_pre_status", rd, 32'h104 | PB);
      repeat (21) @(negedge i_clk);
      rst = 1'b0;
      @(negedge i_clk);
      rst = 1'b1;
      chk("t5_txd", {31'd0, txd}, 32'd1);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      bus_read(A_ST, rd);   chk("t5_status", rd, 32'h2 | PB);
      bus_read(A_DIV, rd);  chk("t5_div", rd, DIV_RST);
      repeat (20) @(negedge i_clk);
      chk("t5_stays_idle", {30'd0, busy, txd}, 32'd1);

      // Address decode
      bus_read(BASE + 32'h14, rd); chk("t6_out_status", rd, 32'd0);
      bus_read(BASE + 32'h18, rd); chk("t6_out_div", rd, 32'd0);
      bus_write(BASE + 32'h10, 32'h77);
      bus_read(A_ST, rd);   chk("t6_level0", rd, 32'h2 | PB);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      bus_read(A_TX, rd);   chk("t6_txdata_rd", rd, 32'd0);
      bus_write(A_RSVD, 32'hFFFF_FFFF);
      bus_read(A_RSVD, rd); chk("t6_rsvd_rd", rd, 32'd0);
      bus_read(A_DIV, rd);  chk("t6_div_kept", rd, DIV_RST);
      bus_read(A_ST + 32'h3, rd); chk("t6_low_bits_ignored", rd, 32'h2 | PB);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral that answers CPU load/store requests on the LSU data-memory interface. It buffers written bytes in a small FIFO and serialises them LSB-first on `o_txd` with a programmable baud divisor. It sits beside the LSU IO decode as a bus responder and contributes its read data to the LSU read-data OR-tree.

## Interface
- `BASE_ADDR`, default `32'h1000_4000`: register window base; 16-byte aligned.
- `CLK_HZ`, default `50_000_000`: core clock frequency.
- `BAUD`, default `115_200`: reset baud rate; reset divisor is `CLK_HZ/BAUD - 1`, truncated to 16 bits.
- `FIFO_DEPTH`, default `8`: TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- `i_clk` in 1: clock.
- `rst` in 1: reset. Reset is `rst`, synchronous, active-low; the clock is `i_clk`.
- `i_we` in 1: store strobe from the LSU.
- `i_re` in 1: load strobe from the LSU.
- `i_addr` in 32: byte address.
- `i_wdata` in 32: store data.
- `o_rdata` out 32: load data. Combinational. Zero when the block is not selected or `i_re`=0.
- `o_txd` out 1: serial output. Registered. Idle high.
- `o_busy` out 1: high while the FIFO is non-empty or a frame is in flight.

## Operation
- Select: `sel = (i_addr[31:4] == BASE_ADDR[31:4])`. Register offset is `i_addr[3:2]`; `i_addr[1:0]` is ignored.
- Offset 0, TXDATA:
  - Write pushes `i_wdata[7:0]`.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0 full
  - bit1 empty
  - bit2 tx_active
  - bit3 overflow (sticky)
  - bits[11:8] FIFO level
  - all other bits 0
- Offset 1, STATUS (write): `i_wdata[3]`=1 clears overflow. Other bits are ignored.
- Offset 2, DIV: 16-bit divisor in bits[15:0]. Read and write; upper bits read 0. Bit period is DIV+1 cycles. DIV=0 is legal and gives 1 cycle per bit.
- Offset 3: reserved. Writes are ignored; reads return 0.
- Push while full:
  - The byte is dropped and overflow is set.
  - Fullness is evaluated before any same-cycle pop, so a push coinciding with a pop on a full FIFO is still dropped.
- FSM states:
  - IDLE: `o_txd`=1. If FIFO is non-empty: pop into shift register, latch DIV into the frame shadow, go to START.
  - START: `o_txd`=0 for one bit period, then go to DATA.
  - DATA: 8 bit periods, LSB first, using a 3-bit bit index. After the 8th bit go to STOP (or PARITY when configured).
  - STOP: `o_txd`=1 for one bit period, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle when the FIFO is non-empty. The gap between the end of one stop bit and the next start bit is therefore 1 cycle.
- DIV writes during a frame take effect at the next frame only (shadowed).
- tx_active is 1 in any state except IDLE.

## Timing
- Reset values:
  - `o_txd`=1, `o_busy`=0, `o_rdata`=0.
  - FSM in IDLE, FIFO empty, overflow=0.
  - DIV = reset divisor.
- A reset asserted mid-frame aborts the frame. `o_txd` is 1 at the next edge and FIFO contents are discarded.
- Write-to-start latency, for a write at edge N into an empty FIFO while idle:
  - level=1 visible after N.
  - FSM pops at N+1.
  - `o_txd` falls at edge N+2.
- Frame length is 10×(DIV+1) cycles, or 11×(DIV+1) with parity.
- The bit timer counts 0..DIV. The bit changes on the edge where the timer wraps to 0.
- Loads are combinational in the same cycle: single-cycle CPU, zero wait states.
- Reads have no side effects.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full is when the MSBs differ and the rest are equal.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for one bit period. STATUS bit4 reads 1.
- Not defined: 8N1 only, and STATUS bit4 reads 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`)
  - register offset constants
  - STATUS bit index constants
  - a function computing the reset divisor
- One sub-module, `sync_fifo`:
  - parameterised width and depth
  - push/pop/full/empty/level
  - write-before-full semantics as above

## Test plan
- Reset, then write DIV=3 and TXDATA=`0x55`: `o_txd` falls 2 cycles after the write. Each bit lasts 4 cycles, giving the pattern 0,1,0,1,0,1,0,1,0,1. The frame totals 40 cycles, then `o_busy` drops.
- Push 9 bytes `0x00..0x08` in 9 consecutive cycles with DIV=0 and FIFO_DEPTH=8: byte `0x08` is dropped and STATUS reads overflow=1. After 8 frames, STATUS reads empty=1.
- Write STATUS with bit3=1: the next read returns overflow=0. A write with bit3=0 leaves overflow set.
- Write DIV=7 mid-frame while DIV=3: the current frame stays at 4 cycles per bit and the next frame uses 8 cycles per bit.
- Assert reset during DATA bit 4: the next cycle shows `o_txd`=1, `o_busy`=0 and STATUS level=0. A DIV read returns the reset divisor.
- Read outside the window (`BASE_ADDR`+`0x10`) with `i_re`=1: `o_rdata`=0. A TXDATA write there does not change the FIFO level.
